uart_sdram_cmd_rx: RTL and testbench

Serial command receiver: an 8N1 UART receiver plus a packet parser that turns host byte packets into SDRAM controller commands. It issues commands on the controller's cmd_ready/cmd_enable port.
It is the inbound counterpart of the existing uart_tx report path. A host PC can write or read any 23-bit SDRAM word over the board's RX pin.

---
 rtl/uart_sdram_cmd_rx.sv | 239 +++++++++++++++++++++++
 tb/tb_uart_sdram_cmd_rx.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_sdram_cmd_rx.sv
// 8N1 UART receiver feeding a packet parser that turns host byte packets
// (0x57 write / 0x52 read) into SDRAM controller commands on cmd_ready/cmd_enable.
module uart_sdram_cmd_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic        clk100,
  input  logic        rst,
  input  logic        uart_rx_pin,
  input  logic        cmd_ready,
  output logic        cmd_enable,
  output logic        cmd_wr,
  output logic [22:0] cmd_address,
  output logic [31:0] cmd_data_in,
  output logic [7:0]  rx_byte,
  output logic        rx_byte_valid,
  output logic        frame_err,
  output logic        pkt_err
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF     = CW'(CLKS_PER_BIT / 2);
  localparam logic [31:0]   TO_LIMIT = 32'(TIMEOUT_BITS * CLKS_PER_BIT);
  localparam logic [7:0]    OP_WR    = 8'h57;
  localparam logic [7:0]    OP_RD    = 8'h52;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  typedef enum logic [1:0] {P_IDLE, P_ADDR, P_DATA, P_ISSUE} p_state_t;

  // Two-flop synchronizer; resets to the line's idle level so reset never looks like a start bit.
  logic sync1_q, rx_s_q;

  always_ff @(posedge clk100 or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= uart_rx_pin;
      rx_s_q  <= sync1_q;
    end
  end

  rx_state_t     rx_state_q, rx_state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frame_err_q, frame_err_d;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk100 or negedge rst) begin
    if (!rst) begin
      rx_state_q  <= IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    rx_state_d  = rx_state_q;
    clk_cnt_d   = clk_cnt_q + 1'b1;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    unique case (rx_state_q)
      IDLE: begin
        clk_cnt_d = '0;
        if (!rx_s_q) begin
          rx_state_d = START;
          bit_cnt_d  = '0;
        end
      end
      START: begin
        if (clk_cnt_q == HALF) begin
          clk_cnt_d  = '0;
          rx_state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) rx_state_d = STOP;
        end
      end
      STOP: begin
        // Return to IDLE straight after the stop sample so a following start bit is caught early.
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d  = '0;
          rx_state_d = IDLE;
          if (rx_s_q) begin
            rx_byte_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: rx_state_d = IDLE;
    endcase
  end

  p_state_t    p_state_q, p_state_d;
  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] to_cnt_q, to_cnt_d;
  logic [14:0] addr_sh_q, addr_sh_d;
  logic [23:0] data_sh_q, data_sh_d;
  logic        cmd_en_q, cmd_en_d;
  logic        cmd_wr_q, cmd_wr_d;
  logic [22:0] cmd_addr_q, cmd_addr_d;
  logic [31:0] cmd_data_q, cmd_data_d;
  logic        pkt_err_q, pkt_err_d;

  always_ff @(posedge clk100 or negedge rst) begin
    if (!rst) begin
      p_state_q  <= P_IDLE;
      byte_cnt_q <= '0;
      to_cnt_q   <= '0;
      addr_sh_q  <= '0;
      data_sh_q  <= '0;
      cmd_en_q   <= 1'b0;
      cmd_wr_q   <= 1'b0;
      cmd_addr_q <= '0;
      cmd_data_q <= '0;
      pkt_err_q  <= 1'b0;
    end else begin
      p_state_q  <= p_state_d;
      byte_cnt_q <= byte_cnt_d;
      to_cnt_q   <= to_cnt_d;
      addr_sh_q  <= addr_sh_d;
      data_sh_q  <= data_sh_d;
      cmd_en_q   <= cmd_en_d;
      cmd_wr_q   <= cmd_wr_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_data_q <= cmd_data_d;
      pkt_err_q  <= pkt_err_d;
    end
  end

  // Address/data assemble in side registers so the command fields only move when a command issues.
  always_comb begin
    p_state_d  = p_state_q;
    byte_cnt_d = byte_cnt_q;
    to_cnt_d   = '0;
    addr_sh_d  = addr_sh_q;
    data_sh_d  = data_sh_q;
    cmd_en_d   = cmd_en_q;
    cmd_wr_d   = cmd_wr_q;
    cmd_addr_d = cmd_addr_q;
    cmd_data_d = cmd_data_q;
    pkt_err_d  = 1'b0;
    unique case (p_state_q)
      P_IDLE: begin
        if (rx_valid_q) begin
          if (rx_byte_q == OP_WR || rx_byte_q == OP_RD) begin
            cmd_wr_d   = (rx_byte_q == OP_WR);
            p_state_d  = P_ADDR;
            byte_cnt_d = '0;
          end else begin
            pkt_err_d = 1'b1;
          end
        end
      end
      P_ADDR, P_DATA: begin
        // A byte in the expiry cycle wins: it is consumed and the timeout restarts from zero.
        if (rx_valid_q) begin
          byte_cnt_d = byte_cnt_q + 3'd1;
          if (p_state_q == P_ADDR) begin
            unique case (byte_cnt_q)
              3'd0:    addr_sh_d = {8'h00, rx_byte_q[6:0]};
              3'd1:    addr_sh_d = {addr_sh_q[6:0], rx_byte_q};
              default: begin
                cmd_addr_d = {addr_sh_q, rx_byte_q};
                byte_cnt_d = '0;
                if (cmd_wr_q) begin
                  p_state_d = P_DATA;
                end else begin
                  p_state_d = P_ISSUE;
                  cmd_en_d  = 1'b1;
                end
              end
            endcase
          end else begin
            data_sh_d = {data_sh_q[15:0], rx_byte_q};
            if (byte_cnt_q == 3'd3) begin
              cmd_data_d = {data_sh_q, rx_byte_q};
              byte_cnt_d = '0;
              p_state_d  = P_ISSUE;
              cmd_en_d   = 1'b1;
            end
          end
        end else if (to_cnt_q + 32'd1 == TO_LIMIT) begin
          pkt_err_d  = 1'b1;
          p_state_d  = P_IDLE;
          byte_cnt_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + 32'd1;
        end
      end
      P_ISSUE: begin
        if (rx_valid_q) pkt_err_d = 1'b1;
        if (cmd_en_q && cmd_ready) begin
          cmd_en_d   = 1'b0;
          p_state_d  = P_IDLE;
          byte_cnt_d = '0;
        end
      end
      default: p_state_d = P_IDLE;
    endcase
  end

  assign cmd_enable    = cmd_en_q;
  assign cmd_wr        = cmd_wr_q;
  assign cmd_address   = cmd_addr_q;
  assign cmd_data_in   = cmd_data_q;
  assign rx_byte       = rx_byte_q;
  assign rx_byte_valid = rx_valid_q;
  assign frame_err     = frame_err_q;
  assign pkt_err       = pkt_err_q;

endmodule

// File: tb/tb_uart_sdram_cmd_rx.sv
// Bench for uart_sdram_cmd_rx: serial byte driver, negedge event monitor and a
// packet-level decode model that predicts each command the controller should see.
`timescale 1ns/1ps
module tb_uart_sdram_cmd_rx;

  localparam int CPB       = 8;
  localparam int TOB       = 16;
  localparam int TO_CYCLES = TOB * CPB;

  logic        clk100 = 1'b0;
  logic        rst = 1'b0;
  logic        uart_rx_pin = 1'b1;
  logic        cmd_ready = 1'b0;
  logic        cmd_enable, cmd_wr;
  logic [22:0] cmd_address;
  logic [31:0] cmd_data_in;
  logic [7:0]  rx_byte;
  logic        rx_byte_valid, frame_err, pkt_err;

  int checks = 0;
  int errors = 0;

  always #5 clk100 = ~clk100;

  uart_sdram_cmd_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .clk100        (clk100),
    .rst           (rst),
    .uart_rx_pin   (uart_rx_pin),
    .cmd_ready     (cmd_ready),
    .cmd_enable    (cmd_enable),
    .cmd_wr        (cmd_wr),
    .cmd_address   (cmd_address),
    .cmd_data_in   (cmd_data_in),
    .rx_byte       (rx_byte),
    .rx_byte_valid (rx_byte_valid),
    .frame_err     (frame_err),
    .pkt_err       (pkt_err)
  );

  typedef struct packed {
    logic        wr;
    logic [22:0] addr;
    logic [31:0] data;
  } cmd_t;

  // Monitor state: written only by the monitor processes below.
  cmd_t       acc_q[$];
  logic [7:0] got_bytes[$];
  int         n_frame = 0, n_pkt = 0, n_en = 0, n_stab = 0;
  int         cyc = 0, last_valid_cyc = 0, last_pkt_cyc = 0;
  cmd_t       held;
  logic       en_prev = 1'b0;

  logic [31:0] model_data = 32'd0;

  always @(posedge clk100) cyc++;

  always @(negedge clk100) begin
    if (rx_byte_valid) begin
      got_bytes.push_back(rx_byte);
      last_valid_cyc = cyc;
    end
    if (frame_err) n_frame++;
    if (pkt_err) begin
      n_pkt++;
      last_pkt_cyc = cyc;
    end
    if (cmd_enable) begin
      n_en++;
      if (en_prev && ({cmd_wr, cmd_address, cmd_data_in} != held)) n_stab++;
      held = {cmd_wr, cmd_address, cmd_data_in};
      if (cmd_ready) acc_q.push_back(held);
    end
    en_prev = cmd_enable;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation still running at %0t, limit 5ms", $time);
    $fatal(1, "watchdog");
  end

  // Packet-level model: what a host packet means, independent of how it is parsed.
  function automatic cmd_t decode(input logic [7:0] b [8], input logic [31:0] prev);
    cmd_t        c;
    int unsigned a;
    int unsigned d;
    a = (int'(b[1]) % 128) * 65536 + int'(b[2]) * 256 + int'(b[3]);
    d = int'(b[4]) * 16777216 + int'(b[5]) * 65536 + int'(b[6]) * 256 + int'(b[7]);
    c.wr   = (b[0] == 8'h57);
    c.addr = a[22:0];
    c.data = c.wr ? d : prev;
    return c;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(posedge clk100); #1;
    uart_rx_pin = 1'b0;
    repeat (CPB) @(posedge clk100);
    for (int i = 0; i < 8; i++) begin
      #1 uart_rx_pin = b[i];
      repeat (CPB) @(posedge clk100);
    end
    #1 uart_rx_pin = stop_bit;
    repeat (CPB) @(posedge clk100);
    #1 uart_rx_pin = 1'b1;
    repeat (CPB) @(posedge clk100);
  endtask

  task automatic send_pkt(input logic [7:0] b [8]);
    int n;
    n = (b[0] == 8'h57) ? 8 : 4;
    for (int i = 0; i < n; i++) send_byte(b[i], 1'b1);
  endtask

  task automatic wait_cmds(input int target, input string name);
    int t;
    t = 0;
    while (acc_q.size() < target && t < 400) begin
      @(negedge clk100);
      t++;
    end
    checks++;
    if (acc_q.size() < target) begin
      errors++;
      $display("FAIL %s accept: got %0d commands, need %0d", name, acc_q.size(), target);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk100);
    checks++;
    if ({cmd_enable, cmd_wr, cmd_address, cmd_data_in, rx_byte, rx_byte_valid, frame_err, pkt_err} !== '0) begin
      errors++;
      $display("FAIL reset_state: got en=%b wr=%b addr=%h data=%h byte=%h v=%b fe=%b pe=%b, need all 0",
               cmd_enable, cmd_wr, cmd_address, cmd_data_in, rx_byte, rx_byte_valid, frame_err, pkt_err);
    end
    @(posedge clk100); #1 rst = 1'b1;
    repeat (4) @(posedge clk100);
  endtask

  task automatic test_write();
    logic [7:0] b [8];
    cmd_t exp;
    int   a0, en0, b0, p0, f0;
    b = '{8'h57, 8'h00, 8'h00, 8'h64, 8'h00, 8'h00, 8'h02, 8'h9A};
    exp = decode(b, model_data);
    a0 = acc_q.size(); en0 = n_en; b0 = got_bytes.size(); p0 = n_pkt; f0 = n_frame;
    @(posedge clk100); #1 cmd_ready = 1'b1;
    send_pkt(b);
    wait_cmds(a0 + 1, "write");
    repeat (4) @(negedge clk100);
    checks++;
    if (acc_q.size() != a0 + 1 || acc_q[a0] !== exp || exp.addr !== 23'd100 || exp.data !== 32'd666) begin
      errors++;
      $display("FAIL write_cmd: got n=%0d cmd=%h, need n=%0d wr=1 addr=100 data=666", acc_q.size() - a0,
               (acc_q.size() > a0) ? acc_q[a0] : '0, 1);
    end
    checks++;
    if (n_en - en0 != 1) begin
      errors++;
      $display("FAIL write_en_width: got %0d enable cycles, need 1", n_en - en0);
    end
    checks++;
    if (got_bytes.size() - b0 != 8 || got_bytes[b0+7] !== 8'h9A || got_bytes[b0] !== 8'h57) begin
      errors++;
      $display("FAIL write_bytes: got %0d valid pulses, need 8 (57..9A)", got_bytes.size() - b0);
    end
    checks++;
    if (n_pkt != p0 || n_frame != f0) begin
      errors++;
      $display("FAIL write_errs: got pkt_err=%0d frame_err=%0d, need 0 0", n_pkt - p0, n_frame - f0);
    end
    model_data = exp.data;
  endtask

  task automatic test_read_wait();
    logic [7:0] b [8];
    cmd_t exp;
    int   a0;
    b = '{8'h52, 8'h80, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00};
    exp = decode(b, model_data);
    a0 = acc_q.size();
    @(posedge clk100); #1 cmd_ready = 1'b0;
    send_pkt(b);
    repeat (50) @(negedge clk100);
    checks++;
    if (cmd_enable !== 1'b1 || {cmd_wr, cmd_address, cmd_data_in} !== exp || exp.addr !== 23'h001234) begin
      errors++;
      $display("FAIL read_hold: got en=%b wr=%b addr=%h data=%h, need en=1 wr=0 addr=001234 data=%h",
               cmd_enable, cmd_wr, cmd_address, cmd_data_in, exp.data);
    end
    checks++;
    if (n_stab != 0) begin
      errors++;
      $display("FAIL read_stable: got %0d field changes while enabled, need 0", n_stab);
    end
    @(posedge clk100); #1 cmd_ready = 1'b1;
    wait_cmds(a0 + 1, "read");
    @(negedge clk100);
    checks++;
    if (cmd_enable !== 1'b0 || acc_q.size() != a0 + 1 || acc_q[a0] !== exp) begin
      errors++;
      $display("FAIL read_accept: got en=%b accepted=%0d, need en=0 accepted=1", cmd_enable, acc_q.size() - a0);
    end
  endtask

  task automatic test_errors();
    int b0, p0, f0;
    b0 = got_bytes.size(); p0 = n_pkt; f0 = n_frame;
    send_byte(8'h41, 1'b1);
    send_byte(8'h55, 1'b0);
    repeat (10) @(negedge clk100);
    checks++;
    if (n_pkt - p0 != 1 || n_frame - f0 != 1) begin
      errors++;
      $display("FAIL err_pulses: got pkt_err=%0d frame_err=%0d, need 1 1", n_pkt - p0, n_frame - f0);
    end
    checks++;
    if (rx_byte !== 8'h41 || got_bytes.size() - b0 != 1) begin
      errors++;
      $display("FAIL err_byte: got rx_byte=%h valids=%0d, need 41 1", rx_byte, got_bytes.size() - b0);
    end
  endtask

  task automatic test_glitch();
    int b0, f0;
    b0 = got_bytes.size(); f0 = n_frame;
    @(posedge clk100); #1 uart_rx_pin = 1'b0;
    repeat (3) @(posedge clk100);
    #1 uart_rx_pin = 1'b1;
    repeat (3 * CPB) @(negedge clk100);
    checks++;
    if (got_bytes.size() != b0 || n_frame != f0) begin
      errors++;
      $display("FAIL glitch: got valids=%0d frame_err=%0d, need 0 0", got_bytes.size() - b0, n_frame - f0);
    end
    send_byte(8'hA5, 1'b1);
    checks++;
    if (rx_byte !== 8'hA5 || got_bytes.size() - b0 != 1) begin
      errors++;
      $display("FAIL glitch_next: got rx_byte=%h valids=%0d, need a5 1", rx_byte, got_bytes.size() - b0);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] b [8];
    cmd_t exp;
    int   p0, a0, t, gap;
    p0 = n_pkt; a0 = acc_q.size();
    send_byte(8'h57, 1'b1);
    send_byte(8'h00, 1'b1);
    t = 0;
    while (n_pkt == p0 && t < TO_CYCLES + 40) begin
      @(negedge clk100);
      t++;
    end
    gap = last_pkt_cyc - last_valid_cyc;
    checks++;
    if (n_pkt - p0 != 1 || gap < TO_CYCLES - 2 || gap > TO_CYCLES + 2) begin
      errors++;
      $display("FAIL timeout: got %0d pkt_err after %0d cycles, need 1 after about %0d", n_pkt - p0, gap, TO_CYCLES);
    end
    b = '{8'h52, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    exp = decode(b, model_data);
    send_pkt(b);
    wait_cmds(a0 + 1, "post_timeout");
    checks++;
    if (acc_q.size() != a0 + 1 || acc_q[a0] !== exp) begin
      errors++;
      $display("FAIL post_timeout_cmd: got n=%0d cmd=%h, need 1 cmd=%h", acc_q.size() - a0,
               (acc_q.size() > a0) ? acc_q[a0] : '0, exp);
    end
  endtask

  task automatic test_overrun_reset();
    logic [7:0] b [8];
    cmd_t exp;
    int   p0, a0, b0;
    b = '{8'h52, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00};
    exp = decode(b, model_data);
    @(posedge clk100); #1 cmd_ready = 1'b0;
    send_pkt(b);
    p0 = n_pkt; a0 = acc_q.size();
    send_byte(8'h52, 1'b1);
    repeat (4) @(negedge clk100);
    checks++;
    if (n_pkt - p0 != 1 || cmd_enable !== 1'b1 || {cmd_wr, cmd_address, cmd_data_in} !== exp) begin
      errors++;
      $display("FAIL overrun: got pkt_err=%0d en=%b wr=%b addr=%h data=%h, need 1 1 %h", n_pkt - p0,
               cmd_enable, cmd_wr, cmd_address, cmd_data_in, exp);
    end
    @(posedge clk100); #1 uart_rx_pin = 1'b0;
    repeat (3 * CPB) @(posedge clk100);
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({cmd_enable, cmd_wr, cmd_address, cmd_data_in, rx_byte, rx_byte_valid, frame_err, pkt_err} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got en=%b wr=%b addr=%h data=%h byte=%h, need all 0",
               cmd_enable, cmd_wr, cmd_address, cmd_data_in, rx_byte);
    end
    uart_rx_pin = 1'b1;
    model_data = 32'd0;
    repeat (5) @(posedge clk100);
    #1 rst = 1'b1;
    b0 = got_bytes.size();
    cmd_ready = 1'b1;
    repeat (12 * CPB) @(negedge clk100);
    checks++;
    if (acc_q.size() != a0 || got_bytes.size() != b0 || cmd_enable !== 1'b0) begin
      errors++;
      $display("FAIL reset_drop: got cmds=%0d bytes=%0d en=%b, need 0 0 0", acc_q.size() - a0,
               got_bytes.size() - b0, cmd_enable);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b [8];
    cmd_t exp;
    int   a0, p0, f0, dly;
    p0 = n_pkt; f0 = n_frame;
    for (int k = 0; k < 8; k++) begin
      b[0] = ($urandom_range(0, 1) == 1) ? 8'h57 : 8'h52;
      for (int i = 1; i < 8; i++) b[i] = 8'($urandom_range(0, 255));
      exp = decode(b, model_data);
      dly = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 30)) : 0;
      a0 = acc_q.size();
      @(posedge clk100); #1 cmd_ready = (dly == 0);
      send_pkt(b);
      repeat (dly) @(posedge clk100);
      #1 cmd_ready = 1'b1;
      wait_cmds(a0 + 1, "random");
      checks++;
      if (acc_q.size() != a0 + 1 || acc_q[a0] !== exp) begin
        errors++;
        $display("FAIL random_cmd[%0d]: got cmd=%h, need %h", k, (acc_q.size() > a0) ? acc_q[a0] : '0, exp);
      end
      model_data = exp.data;
    end
    checks++;
    if (n_pkt != p0 || n_frame != f0 || n_stab != 0) begin
      errors++;
      $display("FAIL random_errs: got pkt_err=%0d frame_err=%0d unstable=%0d, need 0 0 0",
               n_pkt - p0, n_frame - f0, n_stab);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_errors();
    test_glitch();
    test_timeout();
    test_overrun_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
